// File: rtl/trex_sprite_render.sv
// Animated T-rex sprite renderer: 2-stage pixel pipeline around a 1-cycle sprite ROM.
// Define TREX_COLLISION_EN to add the obs_pix input and sticky hit output.
module trex_sprite_render #(
  parameter int unsigned SPR_W    = 20,
  parameter int unsigned SPR_H    = 22,
  parameter int unsigned ROM_AW   = 10,
  parameter int unsigned ANIM_DIV = 6,
  parameter logic [9:0]  INIT_X   = 10'd40,
  parameter logic [8:0]  INIT_Y   = 9'd400,
  parameter logic [11:0] FG_RGB   = 12'h535,
  parameter logic [11:0] BG_RGB   = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_clk,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              active,
  input  logic              animate,
  input  logic              screened,
  input  logic              Hsync_i,
  input  logic              Vsync_i,
  input  logic [9:0]        pos_x,
  input  logic [8:0]        pos_y,
  input  logic              pos_wr,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_data,
`ifdef TREX_COLLISION_EN
  input  logic              obs_pix,
  output logic              hit,
`endif
  output logic [11:0]       rgb,
  output logic              Hsync_o,
  output logic              Vsync_o
);

  localparam int unsigned CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [9:0]        pend_x_q, pend_x_d, live_x_q, live_x_d;
  logic [8:0]        pend_y_q, pend_y_d, live_y_q, live_y_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              sel_q, sel_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              act1_q, act1_d, inside1_q, inside1_d;
  logic              hs1_q, hs1_d, vs1_q, vs1_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d;
  logic [10:0]       x_end_s, y_end_s;
  logic [9:0]        dx_s;
  logic [8:0]        dy_s;
  logic              inside_s;
  logic [ROM_AW-1:0] addr_s;
`ifdef TREX_COLLISION_EN
  logic              hit_q, hit_d;
`endif

  // Position, animation and both pipeline stages.
  always_comb begin
    // pend_*_d already holds pos_* when pos_wr coincides with animate (bypass).
    pend_x_d = pos_wr ? pos_x : pend_x_q;
    pend_y_d = pos_wr ? pos_y : pend_y_q;
    live_x_d = animate ? pend_x_d : live_x_q;
    live_y_d = animate ? pend_y_d : live_y_q;

    frame_cnt_d = frame_cnt_q;
    sel_d       = sel_q;
    if (screened) begin
      if (frame_cnt_q == CNT_W'(ANIM_DIV - 1)) begin
        frame_cnt_d = CNT_W'(0);
        sel_d       = ~sel_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
    x_end_s  = {1'b0, live_x_q} + 11'(SPR_W);
    y_end_s  = {2'b00, live_y_q} + 11'(SPR_H);
    inside_s = active && (x >= live_x_q) && ({1'b0, x} < x_end_s)
                      && (y >= live_y_q) && ({2'b00, y} < y_end_s);
    dx_s     = x - live_x_q;
    dy_s     = y - live_y_q;
    addr_s   = (sel_q ? ROM_AW'(SPR_W * SPR_H) : ROM_AW'(0))
             + ROM_AW'(dy_s) * ROM_AW'(SPR_W) + ROM_AW'(dx_s);

    rom_addr_d = (pixel_clk && inside_s) ? addr_s : rom_addr_q;
    act1_d     = pixel_clk ? active   : act1_q;
    inside1_d  = pixel_clk ? inside_s : inside1_q;
    hs1_d      = pixel_clk ? Hsync_i  : hs1_q;
    vs1_d      = pixel_clk ? Vsync_i  : vs1_q;

    if (pixel_clk) begin
      if (!act1_q) begin
        rgb_d = 12'h000;
      end else begin
        rgb_d = (inside1_q && rom_data) ? FG_RGB : BG_RGB;
      end
    end else begin
      rgb_d = rgb_q;
    end
    hs2_d = pixel_clk ? hs1_q : hs2_q;
    vs2_d = pixel_clk ? vs1_q : vs2_q;

`ifdef TREX_COLLISION_EN
    if (pixel_clk && inside1_q && rom_data && obs_pix) begin
      hit_d = 1'b1;
    end else begin
      hit_d = screened ? 1'b0 : hit_q;
    end
`endif
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_x_q    <= INIT_X;
      pend_y_q    <= INIT_Y;
      live_x_q    <= INIT_X;
      live_y_q    <= INIT_Y;
      frame_cnt_q <= CNT_W'(0);
      sel_q       <= 1'b0;
      rom_addr_q  <= ROM_AW'(0);
      act1_q      <= 1'b0;
      inside1_q   <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      rgb_q       <= 12'h000;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
`ifdef TREX_COLLISION_EN
      hit_q       <= 1'b0;
`endif
    end else begin
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      live_x_q    <= live_x_d;
      live_y_q    <= live_y_d;
      frame_cnt_q <= frame_cnt_d;
      sel_q       <= sel_d;
      rom_addr_q  <= rom_addr_d;
      act1_q      <= act1_d;
      inside1_q   <= inside1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      rgb_q       <= rgb_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
`ifdef TREX_COLLISION_EN
      hit_q       <= hit_d;
`endif
    end
  end

  assign rom_addr = rom_addr_q;
  assign rgb      = rgb_q;
  assign Hsync_o  = hs2_q;
  assign Vsync_o  = vs2_q;
`ifdef TREX_COLLISION_EN
  assign hit      = hit_q;
`endif

endmodule

// File: tb/tb_trex_sprite_render.sv
// Bench for trex_sprite_render: random pixel streams against a behavioural sprite model,
// expected outputs queued at issue time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_trex_sprite_render;
  localparam int W = 20, H = 22, SZ = W * H, DIV = 6;
  localparam logic [11:0] FG = 12'h535, BG = 12'hFFF;

  typedef struct { int idx; logic [11:0] rgb; logic hs; logic vs; } exp_t;
  typedef struct { int idx; logic [9:0] addr; } aexp_t;

  logic clk = 1'b0;
  logic rst, pixel_clk, active, animate, screened, hs_i, vs_i, pos_wr;
  logic rom_data = 1'b0;
  logic hs_o, vs_o;
  logic [9:0] x, pos_x, rom_addr;
  logic [8:0] y, pos_y;
  logic [11:0] rgb;
`ifdef TREX_COLLISION_EN
  logic obs_pix, hit;
  int   exp_hit, prev_op;
`endif

  logic rom_mem [0:1023];
  exp_t  q[$];
  aexp_t aq[$];
  int px_live, py_live, px_pend, py_pend, fcnt, sel;
  int sidx, mcnt, n_chk, n_pass;
  exp_t  m_e;
  aexp_t m_a;
  int    m_idx;

  always #5 clk = ~clk;

  trex_sprite_render dut (
    .clk(clk), .rst(rst), .pixel_clk(pixel_clk), .x(x), .y(y), .active(active),
    .animate(animate), .screened(screened), .Hsync_i(hs_i), .Vsync_i(vs_i),
    .pos_x(pos_x), .pos_y(pos_y), .pos_wr(pos_wr), .rom_addr(rom_addr),
    .rom_data(rom_data),
`ifdef TREX_COLLISION_EN
    .obs_pix(obs_pix), .hit(hit),
`endif
    .rgb(rgb), .Hsync_o(hs_o), .Vsync_o(vs_o)
  );

  // 1-cycle synchronous sprite ROM
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Monitor: output after strobe m belongs to the pixel captured at strobe m-1.
  always @(posedge clk) begin
    if (pixel_clk === 1'b1 && rst === 1'b1) begin
      m_idx = mcnt;
      mcnt++;
      #1;
      if (q.size() == 0 || q[0].idx != m_idx - 1) begin
        n_chk++;
        $display("FAIL order: no expected entry for strobe %0d", m_idx - 1);
      end else begin
        m_e = q.pop_front();
        chk("rgb", rgb, m_e.rgb);
        chk("hsync", hs_o, m_e.hs);
        chk("vsync", vs_o, m_e.vs);
      end
      if (aq.size() > 0 && aq[0].idx == m_idx) begin
        m_a = aq.pop_front();
        chk("rom_addr", rom_addr, m_a.addr);
      end
    end
  end

  task automatic pix(input int xi, input int yi, input bit act);
    exp_t e;
    aexp_t a;
    int in, op;
    @(negedge clk);
    x = xi[9:0]; y = yi[8:0]; active = act;
    hs_i = 1'($urandom % 2); vs_i = 1'($urandom % 2);
    in = (act && xi >= px_live && xi < px_live + W && yi >= py_live && yi < py_live + H) ? 1 : 0;
    op = 0;
    if (in != 0) begin
      a.idx  = sidx;
      a.addr = 10'(sel * SZ + (yi - py_live) * W + (xi - px_live));
      aq.push_back(a);
      op = rom_mem[a.addr] ? 1 : 0;
    end
    e.idx = sidx;
    e.rgb = !act ? 12'h000 : ((op != 0) ? FG : BG);
    e.hs  = hs_i;
    e.vs  = vs_i;
    q.push_back(e);
    sidx++;
    pixel_clk = 1'b1;
`ifdef TREX_COLLISION_EN
    obs_pix = 1'($urandom % 2);
    if (obs_pix && prev_op != 0) exp_hit = 1;
    prev_op = op;
`endif
    @(negedge clk);
    pixel_clk = 1'b0;
`ifdef TREX_COLLISION_EN
    chk("hit", hit, exp_hit);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse(input bit an, input bit sc, input bit wr, input int px, input int py);
    @(negedge clk);
    animate = an; screened = sc; pos_wr = wr; pos_x = px[9:0]; pos_y = py[8:0];
    if (wr) begin px_pend = px; py_pend = py; end
    if (an) begin px_live = px_pend; py_live = py_pend; end
    if (sc) begin
      fcnt++;
      if (fcnt == DIV) begin fcnt = 0; sel = 1 - sel; end
`ifdef TREX_COLLISION_EN
      exp_hit = 0;
`endif
    end
    @(negedge clk);
    animate = 1'b0; screened = 1'b0; pos_wr = 1'b0;
  endtask

  task automatic end_frame();
    pulse(1'b1, 1'b0, 1'b0, 0, 0);
    pulse(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        pix(xx, yy, ($urandom % 8) != 0);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hs_o, 0);
    chk("rst_vsync", vs_o, 0);
    chk("rst_rom_addr", rom_addr, 0);
`ifdef TREX_COLLISION_EN
    chk("rst_hit", hit, 0);
    exp_hit = 0; prev_op = 0;
`endif
    q.delete(); aq.delete();
    px_live = 40; py_live = 400; px_pend = 40; py_pend = 400; fcnt = 0; sel = 0;
    e.idx = sidx - 1; e.rgb = 12'h000; e.hs = 1'b0; e.vs = 1'b0;
    q.push_back(e);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int rx, ry;
    rst = 1'b0; pixel_clk = 1'b0; active = 1'b0; animate = 1'b0; screened = 1'b0;
    hs_i = 1'b0; vs_i = 1'b0; pos_wr = 1'b0; x = 10'd0; y = 9'd0; pos_x = 10'd0; pos_y = 9'd0;
`ifdef TREX_COLLISION_EN
    obs_pix = 1'b0;
`endif
    sidx = 0; mcnt = 0; n_chk = 0; n_pass = 0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 1'($urandom % 2);
    do_reset();

    // Frame at the reset position.
    scan(30, 69, 395, 425);
    end_frame();
    // Mid-frame pos_wr only takes effect next frame.
    scan(30, 69, 395, 409);
    pulse(1'b0, 1'b0, 1'b1, 100, 200);
    scan(30, 69, 410, 425);
    end_frame();
    scan(95, 125, 195, 225);
    // pos_wr in the same clk as animate.
    pulse(1'b1, 1'b0, 1'b1, 300, 100);
    pulse(1'b0, 1'b1, 1'b0, 0, 0);
    scan(295, 325, 95, 125);
    // Right/bottom clipping without wrap.
    pulse(1'b0, 1'b0, 1'b1, 630, 470);
    end_frame();
    scan(620, 639, 462, 479);
    scan(0, 5, 0, 3);
    // Image select toggles every DIV frames.
    for (int f = 0; f < 14; f++) begin
      scan(630, 634, 470, 473);
      end_frame();
    end
    // Mid-frame reset.
    scan(625, 639, 470, 472);
    do_reset();
    scan(38, 60, 399, 404);
    // Randomised frames with random position posts.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom % 40 == 0) pulse(1'b0, 1'b0, 1'b1, $urandom_range(0, 639), $urandom_range(0, 479));
        rx = px_live + $urandom_range(0, 26) - 3;
        ry = py_live + $urandom_range(0, 28) - 3;
        if ($urandom % 4 == 0) begin rx = $urandom_range(0, 639); ry = $urandom_range(0, 479); end
        if (rx < 0) rx = 0;
        if (rx > 639) rx = 639;
        if (ry < 0) ry = 0;
        if (ry > 479) ry = 479;
        pix(rx, ry, ($urandom % 8) != 0);
      end
      if ($urandom % 2 == 0) pulse(1'b1, 1'b0, 1'b1, $urandom_range(0, 639), $urandom_range(0, 479));
      else pulse(1'b1, 1'b0, 1'b0, 0, 0);
      pulse(1'b0, 1'b1, 1'b0, 0, 0);
    end
    pix(0, 0, 1'b0);
    repeat (4) @(negedge clk);
    chk("drain", q.size() * 16 + aq.size(), 16);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
